// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FP16 datapath blocks:
//   - binary16 field widths, exponent bias and all-ones exponent code
//   - canonical quiet-NaN and +infinity encodings
//   - bit positions inside the 4-bit {invalid, overflow, underflow, inexact}
//     flag vector
//   - state encoding of the sequential multiplier
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MUL,
        S_NORM,
        S_ROUND,
        S_DONE
    } mult_state_e;

endpackage

// File: rtl/seq_fp16_mult_if.sv
// -----------------------------------------------------------------------------
// seq_fp16_mult_if
// 4-phase req/ack bundle between the FPU peripheral (master) and the
// sequential FP16 multiplier (slave).
//   req_in  : request, operands stable while high        (master -> slave)
//   a, b    : FP16 operands                               (master -> slave)
//   ack_out : acknowledge, result/flags valid while high  (slave -> master)
//   result  : FP16 product                                (slave -> master)
//   busy    : operation in progress                       (slave -> master)
//   flags   : {invalid, overflow, underflow, inexact}     (slave -> master)
// -----------------------------------------------------------------------------
interface seq_fp16_mult_if;

    logic        req_in;
    logic [15:0] a;
    logic [15:0] b;
    logic        ack_out;
    logic [15:0] result;
    logic        busy;
    logic [3:0]  flags;

    modport master (
        output req_in, a, b,
        input  ack_out, result, busy, flags
    );

    modport slave (
        input  req_in, a, b,
        output ack_out, result, busy, flags
    );

endinterface

// File: rtl/fp16_round_pack.sv
// -----------------------------------------------------------------------------
// fp16_round_pack
// Combinational round-to-nearest-even and FP16 packing. Overflow saturates to
// signed infinity, underflow flushes to signed zero (no subnormal outputs).
//   sign_i      : result sign
//   exp_i       : biased exponent before rounding (signed, may be out of range)
//   man_i       : 11-bit mantissa including the hidden bit
//   guard_i     : first bit below the mantissa LSB
//   sticky_i    : OR of all bits below the guard bit
//   result_o    : packed FP16 value
//   overflow_o / underflow_o / inexact_o : exception flags
// -----------------------------------------------------------------------------
module fp16_round_pack
    import fpu_pkg::*;
(
    input  logic                sign_i,
    input  logic signed [6:0]   exp_i,
    input  logic [MAN_W:0]      man_i,
    input  logic                guard_i,
    input  logic                sticky_i,
    output logic [15:0]         result_o,
    output logic                overflow_o,
    output logic                underflow_o,
    output logic                inexact_o
);

    logic               round_up;
    logic               carry;
    logic [MAN_W-1:0]   frac_rnd;
    logic signed [7:0]  exp_rnd;

    always_comb begin
        round_up = guard_i & (sticky_i | man_i[0]);
        // Mantissa of all ones rounding up wraps the fraction to zero and
        // bumps the exponent.
        carry    = round_up & (&man_i);
        frac_rnd = man_i[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, round_up};
        exp_rnd  = $signed({exp_i[6], exp_i}) + $signed({7'b0, carry});

        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        inexact_o   = guard_i | sticky_i;
        result_o    = {sign_i, exp_rnd[EXP_W-1:0], frac_rnd};

        if (int'(exp_rnd) >= EXP_MAX) begin
            overflow_o = 1'b1;
            inexact_o  = 1'b1;
            result_o   = FP16_PINF | {sign_i, 15'b0};
        end else if (int'(exp_rnd) <= 0) begin
            underflow_o = 1'b1;
            inexact_o   = 1'b1;
            result_o    = {sign_i, 15'b0};
        end
    end

endmodule

// File: rtl/seq_fp16_mult.sv
// -----------------------------------------------------------------------------
// seq_fp16_mult
// Multi-cycle FP16 multiplier behind a 4-phase req/ack handshake. Mantissas
// are multiplied by a 1-bit-per-cycle shift-add loop; normal operands return
// 15 edges after the capturing edge, special operands after 2 edges.
//   clk   : clock
//   rst_n : asynchronous active-low reset, discards any operation in flight
//   bus   : slave side of seq_fp16_mult_if (req_in/a/b in,
//           ack_out/result/busy/flags out)
// -----------------------------------------------------------------------------
module seq_fp16_mult
    import fpu_pkg::*;
#(
    parameter logic [15:0] NAN_PATTERN = FP16_QNAN
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_fp16_mult_if.slave   bus
);

    mult_state_e        state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [21:0]        mcand_q, mcand_d;
    logic [MAN_W:0]     mplier_q, mplier_d;
    logic [21:0]        prod_q, prod_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [MAN_W:0]     man_q, man_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic [15:0]        result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;

    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, a_inf, a_zero;
    logic               b_nan, b_inf, b_zero;

    logic [15:0]        rp_result;
    logic               rp_ovf, rp_unf, rp_inx;

    assign ea = a_q[MAN_W +: EXP_W];
    assign eb = b_q[MAN_W +: EXP_W];
    assign fa = a_q[MAN_W-1:0];
    assign fb = b_q[MAN_W-1:0];

    // A zero exponent field covers subnormals too: they are flushed to zero.
    assign a_nan  = (ea == EXP_W'(EXP_MAX)) && (fa != '0);
    assign a_inf  = (ea == EXP_W'(EXP_MAX)) && (fa == '0);
    assign a_zero = (ea == '0);
    assign b_nan  = (eb == EXP_W'(EXP_MAX)) && (fb != '0);
    assign b_inf  = (eb == EXP_W'(EXP_MAX)) && (fb == '0);
    assign b_zero = (eb == '0);

    fp16_round_pack u_round_pack (
        .sign_i      (sign_q),
        .exp_i       (exp_q),
        .man_i       (man_q),
        .guard_i     (guard_q),
        .sticky_i    (sticky_q),
        .result_o    (rp_result),
        .overflow_o  (rp_ovf),
        .underflow_o (rp_unf),
        .inexact_o   (rp_inx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        result_d = result_q;
        flags_d  = flags_q;
        ack_d    = ack_q;
        busy_d   = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_in) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end

            S_UNPACK: begin
                sign_d = a_q[15] ^ b_q[15];
                exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb})
                         - $signed(7'(BIAS));
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    result_d               = NAN_PATTERN;
                    flags_d                = '0;
                    flags_d[FLAG_INVALID]  = 1'b1;
                    ack_d                  = 1'b1;
                    state_d                = S_DONE;
                end else if (a_inf || b_inf) begin
                    result_d = FP16_PINF | {a_q[15] ^ b_q[15], 15'b0};
                    flags_d  = '0;
                    ack_d    = 1'b1;
                    state_d  = S_DONE;
                end else if (a_zero || b_zero) begin
                    result_d = {a_q[15] ^ b_q[15], 15'b0};
                    flags_d  = '0;
                    ack_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    mcand_d  = {11'b0, 1'b1, fa};
                    mplier_d = {1'b1, fb};
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end

            // Multiplier consumed LSB first; multiplicand walks left in step.
            S_MUL: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : 22'd0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    state_d = S_NORM;
                end
            end

            // Product of two [1,2) mantissas lies in [1,4): at most one
            // right shift brings the leading one back to the hidden position.
            S_NORM: begin
                if (prod_q[21]) begin
                    man_d    = prod_q[21:11];
                    guard_d  = prod_q[10];
                    sticky_d = |prod_q[9:0];
                    exp_d    = exp_q + 7'sd1;
                end else begin
                    man_d    = prod_q[20:10];
                    guard_d  = prod_q[9];
                    sticky_d = |prod_q[8:0];
                end
                state_d = S_ROUND;
            end

            S_ROUND: begin
                result_d                = rp_result;
                flags_d                 = '0;
                flags_d[FLAG_OVERFLOW]  = rp_ovf;
                flags_d[FLAG_UNDERFLOW] = rp_unf;
                flags_d[FLAG_INEXACT]   = rp_inx;
                ack_d                   = 1'b1;
                state_d                 = S_DONE;
            end

            S_DONE: begin
                if (!bus.req_in) begin
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ack_out = ack_q;
    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.flags   = flags_q;

endmodule

// File: doc/seq_fp16_mult.md
Name: seq_fp16_mult

Overview:
Multi-cycle, synchronous FP16 (IEEE binary16, 1-5-10, bias 15) multiplier core. It sits directly downstream of the TinyQV FPU peripheral's MULT path. It consumes operands a/b under the same 4-phase req/ack handshake the peripheral already drives, and returns result on ack. It uses a shift-add mantissa datapath (1 bit/cycle) to keep area small on the tile, trading latency for gates.

Parameters:
NAN_PATTERN, 16'h7E00, canonical quiet NaN returned for any invalid/NaN case.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_in  in  1  4-phase request; a/b stable while high
a  in  16  FP16 operand A
b  in  16  FP16 operand B
ack_out  out  1  4-phase acknowledge; result valid while high
result  out  16  FP16 product
busy  out  1  high from operand capture until return to IDLE
flags  out  4  {invalid, overflow, underflow, inexact}, valid with ack_out

Behaviour:
- Reset (async, any state): state=IDLE; ack_out=0, result=0, busy=0, flags=0; datapath registers cleared. In-flight operation is discarded; no ack is issued for it.
- States: IDLE, UNPACK, MUL, NORM, ROUND, DONE.
- IDLE: on edge with req_in=1, latch a/b; busy<=1; go to UNPACK. If req_in=0, stay in IDLE.
- UNPACK (edge 2):
  - Classify operands; subnormal inputs are flushed to signed zero.
  - Sign = a[15]^b[15]. Exponent sum = ea+eb-15, 7-bit signed.
  - Special cases go straight to DONE with ack_out<=1 (ack visible after 2 edges):
    - any NaN, or inf*0 -> NAN_PATTERN, invalid=1
    - inf*finite-nonzero -> signed inf (0x7C00|sign<<15)
    - zero*finite -> signed zero
  - Otherwise load 11-bit mantissas (hidden 1) and clear the 22-bit product; go to MUL.
- MUL: 11 edges of shift-add on a 4-bit iteration counter; the last iteration goes to NORM.
- NORM (1 edge): if product[21]=1, shift right by 1 and exp+1. Form 10-bit mantissa, guard bit, sticky bit (OR of remaining low bits).
- ROUND (1 edge):
  - Round-to-nearest-even. A rounding carry out of the mantissa increments exp, with mantissa=0.
  - exp>=31 -> signed inf, overflow=1, inexact=1.
  - exp<=0 -> signed zero, underflow=1, inexact=1 (no subnormal outputs).
  - inexact = guard|sticky otherwise.
  - Go to DONE with ack_out<=1 and result/flags registered.
- Normal-path latency: ack_out high after exactly 15 clock edges counted from the edge that sampled req_in=1.
- DONE:
  - ack_out, result and flags held stable while req_in=1, for any duration.
  - On the edge sampling req_in=0: ack_out<=0, busy<=0, go to IDLE.
  - result and flags keep their last value until the next DONE.
- req_in dropping before ack: computation is not aborted. ack_out rises on entering DONE and falls on the next edge (1-cycle pulse). This is a protocol violation by the master, but the behaviour is deterministic.
- Back-to-back: a new operation is captured only in IDLE. The earliest new capture is the edge after ack_out falls, which requires req_in to have been seen low.
- Operand changes while busy are ignored; operands are latched in IDLE.
- Only result, ack_out, busy and flags are outputs; there is no combinational path from req_in to ack_out.

Decomposition:
- Shared package fpu_pkg holds:
  - FP16 field widths (EXP_W=5, MAN_W=10), BIAS=15, EXP_MAX=31
  - canonical NaN/inf constants
  - flag bit indices
  - state enum for this block
- One natural combinational sub-module: fp16_round_pack. It takes sign, signed exp, 11-bit mantissa, guard and sticky, and returns packed FP16 plus overflow/underflow/inexact. It is reusable by the adder path later.

Test Plan:
- a=0x3C00 (1.0), b=0x4000 (2.0), hold req -> ack_out after 15 edges, result=0x4000, flags=0; drop req -> ack_out=0 next edge, busy=0.
- a=0x3E00 (1.5), b=0x3E00 -> result=0x4080 (2.25). a=0xC000, b=0x3800 -> 0xBC00. a=0x3C01, b=0x3C01 -> 0x3C02, inexact=1.
- a=0x7BFF, b=0x4000 -> 0x7C00, overflow=1, inexact=1. a=0x0400, b=0x0400 -> 0x0000, underflow=1, inexact=1.
- a=0x7C00, b=0x0000 -> 0x7E00, invalid=1, ack after 2 edges. a=0xFC00, b=0x4000 -> 0xFC00. a=0x7E01, b=0x3C00 -> 0x7E00, invalid=1.
- Hold req_in high 5 cycles in DONE -> ack_out/result stable. Change a/b mid-MUL -> result reflects latched operands. Drop req at edge 8 -> 1-cycle ack pulse at edge 15.
- Assert rst_n=0 at edge 6 of a multiply -> ack_out/busy/result/flags=0 immediately. After release, 0x4200*0x4200 -> 0x4880 (9.0) in 15 edges.
